pkt_src_arb: RTL and testbench
==============================

Name: pkt_src_arb

Overview:
- Packet-granular round-robin arbiter that shares the single flow_proc input port among NUM_SRC packet sources.
- Drives flow_proc data_in_vld/sop_in_vld/eop_in_vld/data_in from registered outputs.
- Limits packets in flight inside flow_proc with a credit counter, replenished by the flow_proc feedback (fb_vld & fb_eop).
- Sits between the per-source packet interfaces and U_flow_proc in top.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
DATA_WIDTH, 8, packet data width
MAX_OUTSTD, 2, max packets issued to flow_proc and not yet reported complete by feedback (1..15)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
src_vld  in  NUM_SRC  per-source beat valid
src_sop  in  NUM_SRC  per-source start of packet, qualified by src_vld
src_eop  in  NUM_SRC  per-source end of packet, qualified by src_vld
src_data  in  NUM_SRC*DATA_WIDTH  per-source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
src_rdy  out  NUM_SRC  combinational; beat of source i accepted when src_vld[i] & src_rdy[i]
data_out_vld  out  1  to flow_proc data_in_vld
sop_out_vld  out  1  to flow_proc sop_in_vld
eop_out_vld  out  1  to flow_proc eop_in_vld
data_out  out  DATA_WIDTH  to flow_proc data_in
fb_vld  in  1  flow_proc feedback valid
fb_eop  in  1  flow_proc feedback end-of-packet; fb_vld & fb_eop returns one credit
grant_id  out  $clog2(NUM_SRC)  source owning the port; valid while busy=1
busy  out  1  state == XFER
credit_cnt  out  4  available credits
err_proto  out  1  sticky protocol error
err_credit  out  1  sticky credit overflow

Behaviour:
Reset (async assert, sync release)
- State = IDLE; all data_out_* = 0; grant_id = 0; busy = 0.
- credit_cnt = MAX_OUTSTD; last_grant = NUM_SRC-1, so source 0 has first priority; err_* = 0.
- Reset mid-packet truncates the packet; no eop is emitted.

FSM
- IDLE: src_rdy = 0. A source is eligible when src_vld[i] & src_sop[i].
  - If credit_cnt > 0 and any source is eligible, pick the first eligible source searching from last_grant+1 upward with wrap.
  - Register it as grant_id and go to XFER.
  - A source with vld but no sop in IDLE is not eligible. It stays blocked, no error.
- XFER: src_rdy[grant_id] = 1; all other src_rdy = 0.
  - Each accepted beat appears on data_out_* exactly 1 cycle later. data_out_vld = 1; sop/eop/data copied.
  - No accepted beat: data_out_vld = 0, sop/eop = 0, and data_out holds its previous value.
  - Bubbles within a packet are allowed; grant is held across them.
  - Accepted beat with eop: last_grant = grant_id, go to IDLE.
  - Arbitration costs exactly one IDLE cycle between packets. Minimum gap is one cycle with data_out_vld = 0 after eop.
- Single-beat packet (sop & eop together) is legal: one XFER cycle.

Credits
- Decrement on the first accepted beat of a packet in XFER.
- Increment when fb_vld & fb_eop.
- Decrement and increment in the same cycle: credit_cnt unchanged.
- Increment at credit_cnt == MAX_OUTSTD: saturate and set err_credit.
- credit_cnt is never decremented below 0. Arbitration blocks at 0; a granted packet already holds its credit.

Errors
- err_proto is set in XFER when an accepted non-first beat carries sop.
  - Output sop is forced to 0 for that beat; the beat is passed through.
- err_proto and err_credit clear only on reset.

Width rules
- credit_cnt is a 4-bit unsigned counter.
- grant_id is at least 1 bit wide.

Test Plan:
1. Single source: src 0 sends 4-beat packet A0..A3 -> data_out A0..A3 on 4 consecutive cycles, 1 cycle after acceptance; sop on A0, eop on A3; credit_cnt 2->1; grant_id=0.
2. Fairness: all 4 sources hold 2-beat packets continuously, feedback returns immediately -> grant_id order 0,1,2,3,0; one idle cycle between packets; no source starved.
3. Credit stall: MAX_OUTSTD=2, no feedback, 3 sources request -> two packets issued, credit_cnt=0, busy=0, third blocked. One fb_vld&fb_eop -> third granted on the next cycle.
4. Simultaneous credit events: fb_vld&fb_eop in the same cycle as a new packet's sop beat -> credit_cnt unchanged. Extra fb_eop at credit_cnt=MAX_OUTSTD -> count stays at MAX_OUTSTD, err_credit=1.
5. Protocol error and bubbles: src 1 packet with src_vld low for 2 cycles mid-packet, then a sop on beat 3 -> output gap of 2 cycles, grant held, beat 3 output with sop=0, err_proto=1.
6. Reset mid-packet: assert rst after beat 2 of a 5-beat packet -> all outputs 0 immediately (async); after release, credit_cnt=MAX_OUTSTD, source 0 has first priority.

Source files
------------

// File: rtl/pkt_src_arb.sv
`default_nettype none
// ============================================================================
// Module   : pkt_src_arb
// Purpose  : Packet-granular round-robin arbiter with credit-limited issue
//            into flow_proc.
// Revision : 1.0
// ============================================================================
module pkt_src_arb #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_OUTSTD = 2,
    localparam int GRANT_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_vld,
    input  logic [NUM_SRC-1:0]            src_sop,
    input  logic [NUM_SRC-1:0]            src_eop,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_rdy,
    output logic                          data_out_vld,
    output logic                          sop_out_vld,
    output logic                          eop_out_vld,
    output logic [DATA_WIDTH-1:0]         data_out,
    input  logic                          fb_vld,
    input  logic                          fb_eop,
    output logic [GRANT_W-1:0]            grant_id,
    output logic                          busy,
    output logic [3:0]                    credit_cnt,
    output logic                          err_proto,
    output logic                          err_credit
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_XFER     = 1'b1;
    localparam logic [3:0] CREDIT_MAX = 4'(MAX_OUTSTD);

    logic [0:0]            r_state;
    logic [0:0]            w_next_state;
    logic [GRANT_W-1:0]    r_grant;
    logic [GRANT_W-1:0]    r_last_grant;
    logic [3:0]            r_credit;
    logic                  r_first;
    logic                  r_dvld;
    logic                  r_sop;
    logic                  r_eop;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_err_proto;
    logic                  r_err_credit;

    logic [NUM_SRC-1:0]    w_elig;
    logic [GRANT_W-1:0]    w_pick;
    logic                  w_pick_vld;
    int                    w_idx;
    logic                  w_acc;
    logic                  w_beat_sop;
    logic                  w_beat_eop;
    logic [DATA_WIDTH-1:0] w_beat_data;
    logic                  w_dec;
    logic                  w_inc;
    logic [NUM_SRC-1:0]    w_rdy;

    assign w_elig      = src_vld & src_sop;
    assign w_acc       = (r_state == S_XFER) && src_vld[r_grant];
    assign w_beat_sop  = src_sop[r_grant];
    assign w_beat_eop  = src_eop[r_grant];
    assign w_beat_data = src_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
    assign w_dec       = w_acc & r_first;
    assign w_inc       = fb_vld & fb_eop;

    // Walk farthest-first so the nearest eligible source after last_grant wins.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_idx      = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_idx = int'(r_last_grant) + k;
            if (w_idx >= NUM_SRC) begin
                w_idx = w_idx - NUM_SRC;
            end
            if (w_elig[w_idx]) begin
                w_pick     = GRANT_W'(w_idx);
                w_pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_pick_vld && (r_credit != 4'd0)) w_next_state = S_XFER;
            S_XFER:  if (w_acc && w_beat_eop) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdy = '0;
        if (r_state == S_XFER) begin
            w_rdy[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= GRANT_W'(NUM_SRC - 1);
            r_credit     <= CREDIT_MAX;
            r_first      <= 1'b0;
            r_dvld       <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_data       <= '0;
            r_err_proto  <= 1'b0;
            r_err_credit <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_pick_vld && (r_credit != 4'd0)) begin
                r_grant <= w_pick;
                r_first <= 1'b1;
            end else if (w_acc) begin
                r_first <= 1'b0;
            end
            if (w_acc && w_beat_eop) begin
                r_last_grant <= r_grant;
            end

            r_dvld <= w_acc;
            r_sop  <= w_acc & w_beat_sop & r_first;
            r_eop  <= w_acc & w_beat_eop;
            if (w_acc) begin
                r_data <= w_beat_data;
            end
            if (w_acc && !r_first && w_beat_sop) begin
                r_err_proto <= 1'b1;
            end

            // Simultaneous issue and return cancel out.
            if (w_inc && !w_dec) begin
                if (r_credit >= CREDIT_MAX) begin
                    r_err_credit <= 1'b1;
                end else begin
                    r_credit <= r_credit + 4'd1;
                end
            end else if (w_dec && !w_inc && (r_credit != 4'd0)) begin
                r_credit <= r_credit - 4'd1;
            end
        end
    end

    assign src_rdy      = w_rdy;
    assign data_out_vld = r_dvld;
    assign sop_out_vld  = r_sop;
    assign eop_out_vld  = r_eop;
    assign data_out     = r_data;
    assign grant_id     = r_grant;
    assign busy         = (r_state == S_XFER);
    assign credit_cnt   = r_credit;
    assign err_proto    = r_err_proto;
    assign err_credit   = r_err_credit;

endmodule
`default_nettype wire

// File: tb/tb_pkt_src_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_src_arb
// Purpose  : Scenario tasks plus randomized traffic against a packet-level model.
// Revision : 1.0
// ============================================================================
module tb_pkt_src_arb;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int MX  = 2;
    localparam int GW  = 2;
    localparam int NPK = 5;
    localparam int MB  = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_vld, src_sop, src_eop, src_rdy;
    logic [N*DW-1:0] src_data;
    logic            data_out_vld, sop_out_vld, eop_out_vld;
    logic [DW-1:0]   data_out;
    logic            fb_vld, fb_eop;
    logic [GW-1:0]   grant_id;
    logic            busy;
    logic [3:0]      credit_cnt;
    logic            err_proto, err_credit;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] pd [N][NPK][MB];
    int            plen [N][NPK];
    int            npk [N];

    always #5 clk = ~clk;

    pkt_src_arb #(.NUM_SRC(N), .DATA_WIDTH(DW), .MAX_OUTSTD(MX)) dut (
        .clk(clk), .rst(rst),
        .src_vld(src_vld), .src_sop(src_sop), .src_eop(src_eop), .src_data(src_data),
        .src_rdy(src_rdy),
        .data_out_vld(data_out_vld), .sop_out_vld(sop_out_vld), .eop_out_vld(eop_out_vld),
        .data_out(data_out),
        .fb_vld(fb_vld), .fb_eop(fb_eop),
        .grant_id(grant_id), .busy(busy), .credit_cnt(credit_cnt),
        .err_proto(err_proto), .err_credit(err_credit)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_src;
        src_vld = '0; src_sop = '0; src_eop = '0; src_data = '0;
        fb_vld = 1'b0; fb_eop = 1'b0;
    endtask

    task automatic put(input int s, input logic v, input logic sp, input logic ep, input logic [DW-1:0] d);
        src_vld[s] = v; src_sop[s] = sp; src_eop[s] = ep; src_data[s*DW +: DW] = d;
    endtask

    task automatic do_reset;
        clr_src;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (data_out_vld !== 1'b0 || sop_out_vld !== 1'b0 || eop_out_vld !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b sop=%b eop=%b data=%h, want 0 0 0 00",
                     data_out_vld, sop_out_vld, eop_out_vld, data_out);
        end
        checks++;
        if (busy !== 1'b0 || grant_id !== '0 || src_rdy !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b grant=%0d rdy=%b, want 0 0 0000", busy, grant_id, src_rdy);
        end
        checks++;
        if (credit_cnt !== 4'(MX) || err_proto !== 1'b0 || err_credit !== 1'b0) begin
            errors++;
            $display("FAIL reset_credit: got credit=%0d errp=%b errc=%b, want %0d 0 0",
                     credit_cnt, err_proto, err_credit, MX);
        end
    endtask

    task automatic test_single;
        logic [DW-1:0] a [4];
        a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        do_reset;
        put(0, 1'b1, 1'b1, 1'b0, a[0]);
        tick;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || data_out_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: got busy=%b grant=%0d vld=%b, want 1 0 0", busy, grant_id, data_out_vld);
        end
        for (int b = 0; b < 4; b++) begin
            put(0, 1'b1, b == 0, b == 3, a[b]);
            tick;
            checks++;
            if (data_out_vld !== 1'b1 || sop_out_vld !== (b == 0) || eop_out_vld !== (b == 3) || data_out !== a[b]) begin
                errors++;
                $display("FAIL single_beat%0d: got vld=%b sop=%b eop=%b data=%h, want 1 %b %b %h",
                         b, data_out_vld, sop_out_vld, eop_out_vld, data_out, b == 0, b == 3, a[b]);
            end
        end
        clr_src;
        checks++;
        if (credit_cnt !== 4'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_credit: got credit=%0d busy=%b, want 1 0", credit_cnt, busy);
        end
        tick;
        checks++;
        if (data_out_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_gap: got vld=%b, want 0", data_out_vld);
        end
    endtask

    task automatic test_credit_stall;
        bit            pend [3];
        logic [DW-1:0] seq [4];
        logic [N-1:0]  acc;
        int            nout;
        pend = '{1'b1, 1'b1, 1'b1};
        nout = 0;
        do_reset;
        for (int c = 0; c < 12; c++) begin
            for (int s = 0; s < 3; s++) put(s, pend[s], 1'b1, 1'b1, 8'hC0 + 8'(s));
            acc = src_vld & src_rdy;
            tick;
            for (int s = 0; s < 3; s++) if (acc[s]) pend[s] = 1'b0;
            if (data_out_vld === 1'b1 && nout < 4) begin
                seq[nout] = data_out;
                nout++;
            end
        end
        checks++;
        if (nout != 2 || seq[0] !== 8'hC0 || seq[1] !== 8'hC1 || pend[2] != 1'b1) begin
            errors++;
            $display("FAIL stall_issue: got %0d pkts first=%h second=%h, want 2 pkts C0 C1", nout, seq[0], seq[1]);
        end
        checks++;
        if (credit_cnt !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_block: got credit=%0d busy=%b, want 0 0", credit_cnt, busy);
        end
        fb_vld = 1'b1; fb_eop = 1'b1;
        tick;
        fb_vld = 1'b0; fb_eop = 1'b0;
        checks++;
        if (credit_cnt !== 4'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_return: got credit=%0d busy=%b, want 1 0", credit_cnt, busy);
        end
        tick;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL stall_regrant: got busy=%b grant=%0d, want 1 2", busy, grant_id);
        end
        tick;
        clr_src;
        checks++;
        if (data_out_vld !== 1'b1 || data_out !== 8'hC2 || credit_cnt !== 4'd0) begin
            errors++;
            $display("FAIL stall_third: got vld=%b data=%h credit=%0d, want 1 C2 0", data_out_vld, data_out, credit_cnt);
        end
    endtask

    task automatic test_simul_credit;
        do_reset;
        put(0, 1'b1, 1'b1, 1'b1, 8'h40);
        tick;
        tick;
        clr_src;
        tick;
        put(1, 1'b1, 1'b1, 1'b1, 8'h41);
        tick;
        fb_vld = 1'b1; fb_eop = 1'b1;
        tick;
        checks++;
        if (credit_cnt !== 4'd1 || data_out_vld !== 1'b1 || sop_out_vld !== 1'b1 || data_out !== 8'h41) begin
            errors++;
            $display("FAIL simul_credit: got credit=%0d vld=%b sop=%b data=%h, want 1 1 1 41",
                     credit_cnt, data_out_vld, sop_out_vld, data_out);
        end
        clr_src;
        fb_vld = 1'b1; fb_eop = 1'b1;
        tick;
        checks++;
        if (credit_cnt !== 4'd2 || err_credit !== 1'b0) begin
            errors++;
            $display("FAIL simul_refill: got credit=%0d errc=%b, want 2 0", credit_cnt, err_credit);
        end
        tick;
        clr_src;
        checks++;
        if (credit_cnt !== 4'd2 || err_credit !== 1'b1) begin
            errors++;
            $display("FAIL simul_overflow: got credit=%0d errc=%b, want 2 1", credit_cnt, err_credit);
        end
        tick;
        checks++;
        if (err_credit !== 1'b1) begin
            errors++;
            $display("FAIL simul_sticky: got errc=%b, want 1", err_credit);
        end
    endtask

    task automatic test_proto_bubble;
        do_reset;
        put(1, 1'b1, 1'b1, 1'b0, 8'hB0);
        tick;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL proto_grant: got busy=%b grant=%0d, want 1 1", busy, grant_id);
        end
        tick;
        put(1, 1'b1, 1'b0, 1'b0, 8'hB1);
        tick;
        checks++;
        if (data_out_vld !== 1'b1 || data_out !== 8'hB1 || err_proto !== 1'b0) begin
            errors++;
            $display("FAIL proto_b1: got vld=%b data=%h errp=%b, want 1 B1 0", data_out_vld, data_out, err_proto);
        end
        put(1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int g = 0; g < 2; g++) begin
            tick;
            checks++;
            if (data_out_vld !== 1'b0 || sop_out_vld !== 1'b0 || data_out !== 8'hB1 || busy !== 1'b1 || grant_id !== 2'd1) begin
                errors++;
                $display("FAIL proto_gap%0d: got vld=%b sop=%b data=%h busy=%b grant=%0d, want 0 0 B1 1 1",
                         g, data_out_vld, sop_out_vld, data_out, busy, grant_id);
            end
        end
        put(1, 1'b1, 1'b1, 1'b0, 8'hB2);
        tick;
        checks++;
        if (data_out_vld !== 1'b1 || sop_out_vld !== 1'b0 || data_out !== 8'hB2 || err_proto !== 1'b1) begin
            errors++;
            $display("FAIL proto_b2: got vld=%b sop=%b data=%h errp=%b, want 1 0 B2 1",
                     data_out_vld, sop_out_vld, data_out, err_proto);
        end
        put(1, 1'b1, 1'b0, 1'b1, 8'hB3);
        tick;
        clr_src;
        checks++;
        if (eop_out_vld !== 1'b1 || data_out !== 8'hB3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL proto_b3: got eop=%b data=%h busy=%b, want 1 B3 0", eop_out_vld, data_out, busy);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        put(1, 1'b1, 1'b1, 1'b0, 8'h60);
        tick;
        for (int b = 0; b < 2; b++) begin
            put(1, 1'b1, b == 0, 1'b0, 8'h60 + 8'(b));
            tick;
        end
        put(1, 1'b1, 1'b0, 1'b0, 8'h62);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (data_out_vld !== 1'b0 || sop_out_vld !== 1'b0 || eop_out_vld !== 1'b0 || data_out !== '0 ||
            busy !== 1'b0 || grant_id !== '0 || credit_cnt !== 4'(MX)) begin
            errors++;
            $display("FAIL midrst_async: got vld=%b sop=%b eop=%b data=%h busy=%b grant=%0d credit=%0d, want 0 0 0 00 0 0 %0d",
                     data_out_vld, sop_out_vld, eop_out_vld, data_out, busy, grant_id, credit_cnt, MX);
        end
        clr_src;
        tick;
        rst = 1'b0;
        put(0, 1'b1, 1'b1, 1'b1, 8'h70);
        put(1, 1'b1, 1'b1, 1'b1, 8'h71);
        tick;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || credit_cnt !== 4'(MX) || eop_out_vld !== 1'b0) begin
            errors++;
            $display("FAIL midrst_prio: got busy=%b grant=%0d credit=%0d eop=%b, want 1 0 %0d 0",
                     busy, grant_id, credit_cnt, eop_out_vld, MX);
        end
        clr_src;
    endtask

    // Model: sources always present their next sop immediately, so the
    // winner of each arbitration is the next source (after the previous
    // winner) that still has packets left.
    task automatic test_random;
        int cur_p [N];
        int cur_b [N];
        int out_p [N];
        int exp_src, exp_b, last_w, sops, fbs, total, done_pk, cyc, w, idx, p;
        bit prev_eop, fb_now, v;
        logic [N-1:0] acc;
        exp_src = -1; exp_b = 0; last_w = N - 1; sops = 0; fbs = 0; total = 0; done_pk = 0; cyc = 0;
        prev_eop = 1'b0;
        for (int s = 0; s < N; s++) begin
            npk[s] = $urandom_range(1, NPK);
            total += npk[s];
            cur_p[s] = 0; cur_b[s] = 0; out_p[s] = 0;
            for (int q = 0; q < NPK; q++) begin
                plen[s][q] = $urandom_range(1, MB);
                for (int b = 0; b < MB; b++) pd[s][q][b] = 8'($urandom);
            end
        end
        do_reset;
        while (done_pk < total && cyc < 4000) begin
            for (int s = 0; s < N; s++) begin
                if (cur_p[s] < npk[s]) begin
                    v = (cur_b[s] == 0) || ($urandom_range(0, 3) != 0);
                    put(s, v, cur_b[s] == 0, cur_b[s] == plen[s][cur_p[s]] - 1, pd[s][cur_p[s]][cur_b[s]]);
                end else begin
                    put(s, 1'b0, 1'b0, 1'b0, 8'h00);
                end
            end
            fb_now = (sops - fbs > 0) && ($urandom_range(0, 2) == 0);
            fb_eop = fb_now;
            fb_vld = fb_now | ($urandom_range(0, 4) == 0);
            acc = src_vld & src_rdy;
            checks++;
            if (!$onehot0(src_rdy)) begin
                errors++;
                $display("FAIL rand_rdy: got rdy=%b, want at most one bit", src_rdy);
            end
            tick;
            cyc++;
            if (fb_now) fbs++;
            for (int s = 0; s < N; s++) begin
                if (acc[s]) begin
                    if (cur_b[s] == plen[s][cur_p[s]] - 1) begin
                        cur_p[s]++;
                        cur_b[s] = 0;
                    end else begin
                        cur_b[s]++;
                    end
                end
            end
            if (data_out_vld === 1'b1) begin
                if (exp_src < 0) begin
                    w = -1;
                    for (int k = 1; k <= N; k++) begin
                        idx = (last_w + k) % N;
                        if (w < 0 && out_p[idx] < npk[idx]) w = idx;
                    end
                    checks++;
                    if (w < 0 || prev_eop) begin
                        errors++;
                        $display("FAIL rand_start: got beat data=%h, want none (no pending src or no gap)", data_out);
                    end else begin
                        exp_src = w;
                        exp_b = 0;
                        sops++;
                    end
                end
                if (exp_src >= 0) begin
                    p = out_p[exp_src];
                    checks++;
                    if (sop_out_vld !== (exp_b == 0) || eop_out_vld !== (exp_b == plen[exp_src][p] - 1) ||
                        data_out !== pd[exp_src][p][exp_b]) begin
                        errors++;
                        $display("FAIL rand_beat src%0d pkt%0d beat%0d: got sop=%b eop=%b data=%h, want %b %b %h",
                                 exp_src, p, exp_b, sop_out_vld, eop_out_vld, data_out,
                                 exp_b == 0, exp_b == plen[exp_src][p] - 1, pd[exp_src][p][exp_b]);
                    end
                    if (exp_b == plen[exp_src][p] - 1) begin
                        out_p[exp_src]++;
                        last_w = exp_src;
                        exp_src = -1;
                        done_pk++;
                    end else begin
                        exp_b++;
                    end
                end
            end else begin
                checks++;
                if (sop_out_vld !== 1'b0 || eop_out_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle: got sop=%b eop=%b, want 0 0", sop_out_vld, eop_out_vld);
                end
            end
            checks++;
            if (credit_cnt !== 4'(MX - sops + fbs)) begin
                errors++;
                $display("FAIL rand_credit: got %0d, want %0d", credit_cnt, MX - sops + fbs);
            end
            prev_eop = (data_out_vld === 1'b1) && (eop_out_vld === 1'b1);
        end
        clr_src;
        checks++;
        if (done_pk != total) begin
            errors++;
            $display("FAIL rand_timeout: got %0d packets, want %0d", done_pk, total);
        end
        checks++;
        if (err_proto !== 1'b0 || err_credit !== 1'b0) begin
            errors++;
            $display("FAIL rand_errflags: got errp=%b errc=%b, want 0 0", err_proto, err_credit);
        end
    endtask

    initial begin
        rst = 1'b1;
        clr_src;
        test_reset;
        test_single;
        test_credit_stall;
        test_simul_credit;
        test_proto_bubble;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
